mcycle_ctrl_hs: RTL and testbench

//  Next-generation multicycle MIPS control FSM. Drives the datapath muxes, ALU op, PC and register-file writes.

---
 rtl/mcycle_ctrl_hs.sv | 251 +++++++++++++++++++++++++
 tb/tb_mcycle_ctrl_hs.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_ctrl_hs.sv
// Multicycle MIPS control FSM with mem_ready handshake, timeout, byte-lane strobes,
// sticky trap reporting and a retired-instruction counter.
`timescale 1ns/1ps
module mcycle_ctrl_hs #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [6:0]       ext_op,
    input  logic [1:0]       addr_lo,
    input  logic             zflag,
    input  logic             mem_ready,
    output logic             imem_en,
    output logic             dmem_en,
    output logic [3:0]       dmem_wen,
    output logic [1:0]       reg_waddr_sel,
    output logic [1:0]       reg_wdata_sel,
    output logic             reg_wen,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_sel,
    output logic             pc_write,
    output logic             wb_state,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_LUI   = 7'b1001111;
    localparam logic [6:0] OP_ADDIU = 7'b1001001;
    localparam logic [6:0] OP_SLTI  = 7'b1001010;
    localparam logic [6:0] OP_SLTIU = 7'b1001011;
    localparam logic [6:0] OP_ADDU  = 7'b0100001;
    localparam logic [6:0] OP_OR    = 7'b0100101;
    localparam logic [6:0] OP_SLT   = 7'b0101010;
    localparam logic [6:0] OP_SLL   = 7'b0000000;
    localparam logic [6:0] OP_BEQ   = 7'b1000100;
    localparam logic [6:0] OP_BNE   = 7'b1000101;
    localparam logic [6:0] OP_LW    = 7'b1100011;
    localparam logic [6:0] OP_SW    = 7'b1101011;
    localparam logic [6:0] OP_SB    = 7'b1101000;
    localparam logic [6:0] OP_SH    = 7'b1101001;
    localparam logic [6:0] OP_J     = 7'b1000010;
    localparam logic [6:0] OP_JAL   = 7'b1000011;
    localparam logic [6:0] OP_JR    = 7'b0001000;

    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [2:0] ALU_SLTU = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR,
        S_WB_RD, S_WB_RT, S_WB_31, S_PC_UPD, S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      wait_cnt_q, wait_cnt_d;
    logic [1:0]       trap_code_q, trap_code_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       known;
    logic [2:0] ex_alu_op;
    logic [1:0] ex_a_sel, ex_b_sel;
    state_t     ex_next;
    logic       misaligned;
    logic [3:0] wstrb;
    logic       waiting;
    logic       wait_hit;

    // Opcode decode: EXEC-stage ALU setup and successor state.
    always_comb begin
        known     = 1'b1;
        ex_alu_op = ALU_ADD;
        ex_a_sel  = 2'b00;
        ex_b_sel  = 2'b00;
        ex_next   = S_WB_RT;
        case (ext_op)
            OP_LUI:   ex_alu_op = ALU_LUI;
            OP_ADDIU: ex_alu_op = ALU_ADD;
            OP_SLTI:  ex_alu_op = ALU_SLT;
            OP_SLTIU: ex_alu_op = ALU_SLTU;
            OP_ADDU:  begin ex_b_sel = 2'b10; ex_next = S_WB_RD; end
            OP_OR:    begin ex_alu_op = ALU_OR;  ex_b_sel = 2'b10; ex_next = S_WB_RD; end
            OP_SLT:   begin ex_alu_op = ALU_SLT; ex_b_sel = 2'b10; ex_next = S_WB_RD; end
            OP_SLL:   begin ex_alu_op = ALU_SLL; ex_a_sel = 2'b10; ex_b_sel = 2'b01; ex_next = S_WB_RD; end
            OP_BEQ, OP_BNE: begin ex_alu_op = ALU_SUB; ex_b_sel = 2'b10; ex_next = S_PC_UPD; end
            OP_LW:    ex_next = S_MEM_RD;
            OP_SW, OP_SB, OP_SH: ex_next = S_MEM_WR;
            OP_JAL:   begin ex_a_sel = 2'b01; ex_b_sel = 2'b11; ex_next = S_WB_31; end
            OP_J, OP_JR: ex_next = S_PC_UPD;
            default:  known = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = (((ext_op == OP_LW) || (ext_op == OP_SW)) && (addr_lo != 2'b00)) ||
                     ((ext_op == OP_SH) && addr_lo[0]);
        case (ext_op)
            OP_SW:   wstrb = 4'b1111;
            OP_SH:   wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            OP_SB:   wstrb = 4'b0001 << addr_lo;
            default: wstrb = '0;
        endcase
        wait_hit = (MEM_TIMEOUT != 0) && ((wait_cnt_q + 32'd1) == MEM_TIMEOUT);
    end

    always_comb begin
        state_d       = state_q;
        trap_code_d   = trap_code_q;
        wait_cnt_d    = '0;
        waiting       = 1'b0;
        imem_en       = 1'b0;
        dmem_en       = 1'b0;
        dmem_wen      = '0;
        reg_waddr_sel = 2'b00;
        reg_wdata_sel = 2'b00;
        reg_wen       = 1'b0;
        alu_a_sel     = 2'b00;
        alu_b_sel     = 2'b00;
        alu_op        = 3'b000;
        pc_sel        = 2'b00;
        pc_write      = 1'b0;
        wb_state      = 1'b0;
        trap          = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_en  = 1'b1;
                pc_write = mem_ready;
                waiting  = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_op = ALU_ADD;
                if (!known) begin
                    state_d     = S_TRAP;
                    trap_code_d = 2'b01;
                end else if ((ext_op == OP_J) || (ext_op == OP_JR)) begin
                    state_d = S_PC_UPD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_a_sel = ex_a_sel;
                alu_b_sel = ex_b_sel;
                alu_op    = ex_alu_op;
                state_d   = ex_next;
            end
            S_MEM_RD, S_MEM_WR: begin
                if (misaligned) begin
                    state_d     = S_TRAP;
                    trap_code_d = 2'b10;
                end else begin
                    dmem_en = 1'b1;
                    waiting = 1'b1;
                    if (state_q == S_MEM_WR) dmem_wen = wstrb;
                    if (mem_ready) state_d = (state_q == S_MEM_RD) ? S_WB_RT : S_FETCH;
                end
            end
            S_WB_RD: begin
                reg_wen  = 1'b1;
                wb_state = 1'b1;
                state_d  = S_FETCH;
            end
            S_WB_RT: begin
                reg_wen       = 1'b1;
                reg_waddr_sel = 2'b01;
                reg_wdata_sel = (ext_op == OP_LW) ? 2'b01 : 2'b00;
                wb_state      = 1'b1;
                state_d       = S_FETCH;
            end
            S_WB_31: begin
                reg_wen       = 1'b1;
                reg_waddr_sel = 2'b10;
                wb_state      = 1'b1;
                state_d       = S_PC_UPD;
            end
            S_PC_UPD: begin
                wb_state = 1'b1;
                state_d  = S_FETCH;
                case (ext_op)
                    OP_BEQ:        begin pc_sel = 2'b01; pc_write = zflag;  end
                    OP_BNE:        begin pc_sel = 2'b01; pc_write = !zflag; end
                    OP_J, OP_JAL:  begin pc_sel = 2'b10; pc_write = 1'b1;   end
                    OP_JR:         begin pc_sel = 2'b11; pc_write = 1'b1;   end
                    default:       ;
                endcase
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // A stalled access that hits the limit overrides the stay-in-state decision;
        // mem_ready=1 never reaches here, so completion on the limit cycle still advances.
        if (waiting && !mem_ready) begin
            if (wait_hit) begin
                state_d     = S_TRAP;
                trap_code_d = 2'b11;
            end else begin
                wait_cnt_d = wait_cnt_q + 32'd1;
            end
        end

        retired_d = retired_q;
        if ((state_d == S_FETCH) && ((state_q == S_MEM_WR) || (state_q == S_WB_RD) ||
                                     (state_q == S_WB_RT) || (state_q == S_PC_UPD)))
            retired_d = retired_q + CNT_W'(1);

        trap_code = trap_code_q;
        retired   = retired_q;
        // Outputs are combinational, so reset must mask them in the same cycle it is asserted.
        if (!resetn) begin
            imem_en       = 1'b0;
            dmem_en       = 1'b0;
            dmem_wen      = '0;
            reg_waddr_sel = 2'b00;
            reg_wdata_sel = 2'b00;
            reg_wen       = 1'b0;
            alu_a_sel     = 2'b00;
            alu_b_sel     = 2'b00;
            alu_op        = 3'b000;
            pc_sel        = 2'b00;
            pc_write      = 1'b0;
            wb_state      = 1'b0;
            trap          = 1'b0;
            trap_code     = 2'b00;
            retired       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_FETCH;
            wait_cnt_q  <= '0;
            trap_code_q <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            trap_code_q <= trap_code_d;
            retired_q   <= retired_d;
        end
    end

endmodule

// File: tb/tb_mcycle_ctrl_hs.sv
// Directed self-checking bench for mcycle_ctrl_hs: one task per scenario, hand-computed expectations.
`timescale 1ns/1ps
module tb_mcycle_ctrl_hs;

    localparam logic [6:0] OP_ADDU = 7'b0100001;
    localparam logic [6:0] OP_BEQ  = 7'b1000100;
    localparam logic [6:0] OP_BNE  = 7'b1000101;
    localparam logic [6:0] OP_LW   = 7'b1100011;
    localparam logic [6:0] OP_SW   = 7'b1101011;
    localparam logic [6:0] OP_SB   = 7'b1101000;
    localparam logic [6:0] OP_SH   = 7'b1101001;
    localparam logic [6:0] OP_J    = 7'b1000010;
    localparam logic [6:0] OP_JAL  = 7'b1000011;
    localparam logic [6:0] OP_JR   = 7'b0001000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [6:0]  ext_op;
    logic [1:0]  addr_lo;
    logic        zflag;
    logic        mem_ready;
    logic        imem_en, dmem_en, reg_wen, pc_write, wb_state, trap;
    logic [3:0]  dmem_wen;
    logic [1:0]  reg_waddr_sel, reg_wdata_sel, alu_a_sel, alu_b_sel, pc_sel, trap_code;
    logic [2:0]  alu_op;
    logic [31:0] retired;

    int checks = 0;
    int fails  = 0;

    mcycle_ctrl_hs #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .ext_op(ext_op), .addr_lo(addr_lo), .zflag(zflag),
        .mem_ready(mem_ready), .imem_en(imem_en), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
        .reg_waddr_sel(reg_waddr_sel), .reg_wdata_sel(reg_wdata_sel), .reg_wen(reg_wen),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .pc_sel(pc_sel),
        .pc_write(pc_write), .wb_state(wb_state), .trap(trap), .trap_code(trap_code),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Inputs change 2ns after the rising edge; checks follow a further 1ns settle.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        mem_ready = 1'b1;
        cyc();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({imem_en, dmem_en, dmem_wen, reg_wen, pc_write, wb_state, trap} !== 10'b0) begin
            fails++; $display("FAIL reset_enables: got %b required 0", {imem_en, dmem_en, dmem_wen, reg_wen, pc_write, wb_state, trap});
        end
        checks++;
        if ({reg_waddr_sel, reg_wdata_sel, alu_a_sel, alu_b_sel, alu_op, pc_sel, trap_code} !== 15'b0) begin
            fails++; $display("FAIL reset_selects: got %b required 0", {reg_waddr_sel, reg_wdata_sel, alu_a_sel, alu_b_sel, alu_op, pc_sel, trap_code});
        end
        checks++;
        if (retired !== 32'd0) begin fails++; $display("FAIL reset_retired: got %0d required 0", retired); end
        resetn = 1'b1;
        #1;
        checks++;
        if ({imem_en, pc_write, pc_sel} !== 4'b1100) begin
            fails++; $display("FAIL reset_first_fetch: got %b required 1100", {imem_en, pc_write, pc_sel});
        end
    endtask

    task automatic test_addu();
        ext_op = OP_ADDU; mem_ready = 1'b1;
        cyc(); #1;
        checks++;
        if ({imem_en, reg_wen, alu_op} !== 5'b00010) begin fails++; $display("FAIL addu_decode: got %b required 00010", {imem_en, reg_wen, alu_op}); end
        cyc(); #1;
        checks++;
        if ({alu_a_sel, alu_b_sel, alu_op} !== 7'b0010010) begin fails++; $display("FAIL addu_exec: got %b required 0010010", {alu_a_sel, alu_b_sel, alu_op}); end
        cyc(); #1;
        checks++;
        if ({reg_wen, reg_waddr_sel, reg_wdata_sel, wb_state, retired[3:0]} !== 10'b1000010000) begin
            fails++; $display("FAIL addu_wb_rd: got %b required 1000010000", {reg_wen, reg_waddr_sel, reg_wdata_sel, wb_state, retired[3:0]});
        end
        cyc(); #1;
        checks++;
        if ({imem_en, reg_wen} !== 2'b10 || retired !== 32'd1) begin
            fails++; $display("FAIL addu_retire: got en=%b ret=%0d required en=10 ret=1", {imem_en, reg_wen}, retired);
        end
    endtask

    task automatic test_lw_wait();
        int n_en = 0;
        ext_op = OP_LW; addr_lo = 2'b00; mem_ready = 1'b1;
        cyc(); cyc(); #1;
        checks++;
        if ({alu_a_sel, alu_b_sel, alu_op} !== 7'b0000010) begin fails++; $display("FAIL lw_exec: got %b required 0000010", {alu_a_sel, alu_b_sel, alu_op}); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            if (dmem_en === 1'b1 && dmem_wen === 4'b0000 && reg_wen === 1'b0) n_en++;
            cyc();
        end
        checks++;
        if (n_en !== 4) begin fails++; $display("FAIL lw_dmem_en_cycles: got %0d required 4", n_en); end
        mem_ready = 1'b1; #1;
        checks++;
        if ({reg_wen, reg_waddr_sel, reg_wdata_sel, dmem_en} !== 6'b101010) begin
            fails++; $display("FAIL lw_wb_rt: got %b required 101010", {reg_wen, reg_waddr_sel, reg_wdata_sel, dmem_en});
        end
        cyc(); #1;
        checks++;
        if (imem_en !== 1'b1 || retired !== 32'd2) begin fails++; $display("FAIL lw_retire: got en=%b ret=%0d required en=1 ret=2", imem_en, retired); end
    endtask

    task automatic test_stores();
        logic [6:0] ops  [3] = '{OP_SB, OP_SH, OP_SW};
        logic [1:0] adrs [3] = '{2'b10, 2'b10, 2'b00};
        logic [3:0] strb [3] = '{4'b0100, 4'b1100, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            ext_op = ops[i]; addr_lo = adrs[i]; mem_ready = 1'b1;
            cyc(); cyc(); cyc(); #1;
            checks++;
            if ({dmem_en, dmem_wen} !== {1'b1, strb[i]}) begin
                fails++; $display("FAIL store_strobe[%0d]: got %b required %b", i, {dmem_en, dmem_wen}, {1'b1, strb[i]});
            end
            cyc(); #1;
            checks++;
            if (imem_en !== 1'b1 || retired !== 32'(3 + i)) begin
                fails++; $display("FAIL store_retire[%0d]: got en=%b ret=%0d required en=1 ret=%0d", i, imem_en, retired, 3 + i);
            end
        end
        ext_op = OP_SH; addr_lo = 2'b01;
        cyc(); cyc(); cyc(); #1;
        checks++;
        if ({dmem_en, dmem_wen, trap} !== 6'b0) begin fails++; $display("FAIL sh_misaligned_entry: got %b required 000000", {dmem_en, dmem_wen, trap}); end
        cyc(); #1;
        checks++;
        if ({trap, trap_code, imem_en} !== 4'b1100 || retired !== 32'd5) begin
            fails++; $display("FAIL sh_misaligned_trap: got %b ret=%0d required 1100 ret=5", {trap, trap_code, imem_en}, retired);
        end
        do_reset();
    endtask

    task automatic test_branches();
        logic [6:0] ops [3] = '{OP_BEQ, OP_BNE, OP_BEQ};
        logic       zf  [3] = '{1'b0, 1'b0, 1'b1};
        logic       pw  [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            ext_op = ops[i]; zflag = zf[i]; mem_ready = 1'b1;
            cyc(); cyc(); #1;
            checks++;
            if ({alu_b_sel, alu_op} !== 5'b10110) begin fails++; $display("FAIL branch_exec[%0d]: got %b required 10110", i, {alu_b_sel, alu_op}); end
            cyc(); #1;
            checks++;
            if ({pc_write, pc_sel, wb_state} !== {pw[i], 3'b011}) begin
                fails++; $display("FAIL branch_pc_upd[%0d]: got %b required %b", i, {pc_write, pc_sel, wb_state}, {pw[i], 3'b011});
            end
            cyc(); #1;
            checks++;
            if (retired !== 32'(1 + i)) begin fails++; $display("FAIL branch_retire[%0d]: got %0d required %0d", i, retired, 1 + i); end
        end
    endtask

    task automatic test_jumps();
        ext_op = OP_JAL; mem_ready = 1'b1;
        cyc(); cyc(); #1;
        checks++;
        if ({alu_a_sel, alu_b_sel, alu_op} !== 7'b0111010) begin fails++; $display("FAIL jal_exec: got %b required 0111010", {alu_a_sel, alu_b_sel, alu_op}); end
        cyc(); #1;
        checks++;
        if ({reg_wen, reg_waddr_sel, wb_state, pc_write} !== 5'b11010) begin fails++; $display("FAIL jal_wb_31: got %b required 11010", {reg_wen, reg_waddr_sel, wb_state, pc_write}); end
        cyc(); #1;
        checks++;
        if ({pc_write, pc_sel, reg_wen, wb_state} !== 5'b11001) begin fails++; $display("FAIL jal_pc_upd: got %b required 11001", {pc_write, pc_sel, reg_wen, wb_state}); end
        cyc(); #1;
        checks++;
        if (retired !== 32'd4) begin fails++; $display("FAIL jal_retire: got %0d required 4", retired); end

        ext_op = OP_J;
        cyc(); cyc(); #1;
        checks++;
        if ({pc_write, pc_sel, wb_state} !== 4'b1101) begin fails++; $display("FAIL j_pc_upd: got %b required 1101", {pc_write, pc_sel, wb_state}); end
        cyc(); #1;
        checks++;
        if (imem_en !== 1'b1 || retired !== 32'd5) begin fails++; $display("FAIL j_retire: got en=%b ret=%0d required en=1 ret=5", imem_en, retired); end

        ext_op = OP_JR;
        cyc(); cyc(); #1;
        checks++;
        if ({pc_write, pc_sel, wb_state} !== 4'b1111) begin fails++; $display("FAIL jr_pc_upd: got %b required 1111", {pc_write, pc_sel, wb_state}); end
        cyc(); #1;
        checks++;
        if (retired !== 32'd6) begin fails++; $display("FAIL jr_retire: got %0d required 6", retired); end
    endtask

    task automatic test_illegal();
        ext_op = 7'b1111111; mem_ready = 1'b1;
        cyc(); #1;
        checks++;
        if ({alu_op, trap} !== 4'b0100) begin fails++; $display("FAIL illegal_decode: got %b required 0100", {alu_op, trap}); end
        cyc(); #1;
        checks++;
        if ({trap, trap_code, imem_en} !== 4'b1010) begin fails++; $display("FAIL illegal_trap: got %b required 1010", {trap, trap_code, imem_en}); end
        cyc(); cyc(); #1;
        checks++;
        if ({trap, trap_code, imem_en, dmem_en, reg_wen} !== 6'b101000) begin
            fails++; $display("FAIL illegal_sticky: got %b required 101000", {trap, trap_code, imem_en, dmem_en, reg_wen});
        end
        do_reset(); #1;
        checks++;
        if ({trap, trap_code, imem_en} !== 4'b0001) begin fails++; $display("FAIL illegal_cleared: got %b required 0001", {trap, trap_code, imem_en}); end
    endtask

    task automatic test_timeout();
        int bad = 0;
        ext_op = OP_ADDU; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (imem_en !== 1'b1 || trap !== 1'b0) bad++;
            cyc();
        end
        mem_ready = 1'b1;
        cyc(); #1;
        checks++;
        if (bad !== 0 || {imem_en, alu_op, trap} !== 5'b00100) begin
            fails++; $display("FAIL timeout_ready_at_limit: got bad=%0d %b required bad=0 00100", bad, {imem_en, alu_op, trap});
        end
        cyc(); cyc(); cyc(); #1;
        checks++;
        if (imem_en !== 1'b1 || retired !== 32'd1) begin fails++; $display("FAIL timeout_addu_retire: got en=%b ret=%0d required en=1 ret=1", imem_en, retired); end
        mem_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (imem_en !== 1'b1 || trap !== 1'b0) bad++;
            cyc();
        end
        #1;
        checks++;
        if (bad !== 0 || {trap, trap_code, imem_en} !== 4'b1110) begin
            fails++; $display("FAIL fetch_timeout_trap: got bad=%0d %b required bad=0 1110", bad, {trap, trap_code, imem_en});
        end
        do_reset();
    endtask

    task automatic test_reset_mid_store();
        ext_op = OP_SW; addr_lo = 2'b00; mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        mem_ready = 1'b0; #1;
        checks++;
        if ({dmem_en, dmem_wen} !== 5'b11111) begin fails++; $display("FAIL mid_wait_strobe: got %b required 11111", {dmem_en, dmem_wen}); end
        cyc();
        resetn = 1'b0;
        cyc(); #1;
        checks++;
        if ({dmem_en, dmem_wen, imem_en} !== 6'b0 || retired !== 32'd0) begin
            fails++; $display("FAIL mid_reset_drop: got %b ret=%0d required 000000 ret=0", {dmem_en, dmem_wen, imem_en}, retired);
        end
        resetn = 1'b1; mem_ready = 1'b1; #1;
        checks++;
        if ({imem_en, dmem_en, pc_write} !== 3'b101) begin fails++; $display("FAIL mid_reset_fetch: got %b required 101", {imem_en, dmem_en, pc_write}); end
        cyc(); #1;
        checks++;
        if ({imem_en, alu_op, retired[3:0]} !== 8'b00100000) begin
            fails++; $display("FAIL mid_reset_decode: got %b required 00100000", {imem_en, alu_op, retired[3:0]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; ext_op = OP_ADDU; addr_lo = 2'b00; zflag = 1'b0; mem_ready = 1'b1;
        cyc(); cyc();
        test_reset();
        test_addu();
        test_lw_wait();
        test_stores();
        test_branches();
        test_jumps();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
